// File: rtl/parity_frame_serializer.sv
// ============================================================================
// parity_frame_serializer
// UART-style serializer for {data[7:0], parity}: start, 8 data LSB first,
// optional parity slot, stop. Bit timing from an internal baud counter.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_frame_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] data_in_with_parity,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

  generate
    if (CLKS_PER_BIT < 2) begin : g_cpb_check
      $error("parity_frame_serializer: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q;
  logic [8:0]       word_q;
  logic [CNT_W-1:0] baud_q;
  logic [CNT_W-1:0] baud_d;
  logic [2:0]       bit_idx_q;
  logic [2:0]       bit_idx_d;
  logic             serial_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             done_d;
  logic             accept;
  logic             baud_wrap;
  logic [7:0]       data_bits;

  assign data_bits = word_q[8:1];

  always_comb begin
    accept    = tx_valid && ready_q;
    baud_wrap = (baud_q == CNT_LAST);
    baud_d    = baud_wrap ? '0 : baud_q + 1'b1;
    bit_idx_d = bit_idx_q + 3'd1;
    // Registered done must already be high during the final STOP cycle.
    done_d    = (state_q == S_STOP) && (baud_q == CNT_PRE_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      baud_q    <= '0;
      bit_idx_q <= '0;
      serial_q  <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= done_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q   <= S_START;
            word_q    <= data_in_with_parity;
            baud_q    <= '0;
            bit_idx_q <= '0;
            serial_q  <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_START: begin
          baud_q <= baud_d;
          if (baud_wrap) begin
            state_q  <= S_DATA;
            serial_q <= data_bits[0];
          end
        end
        S_DATA: begin
          baud_q <= baud_d;
          if (baud_wrap) begin
            bit_idx_q <= bit_idx_d;
            if (bit_idx_q == 3'd7) begin
              if (PARITY_EN) begin
                state_q  <= S_PARITY;
                serial_q <= word_q[0];
              end else begin
                state_q  <= S_STOP;
                serial_q <= 1'b1;
              end
            end else begin
              serial_q <= data_bits[bit_idx_d];
            end
          end
        end
        S_PARITY: begin
          baud_q <= baud_d;
          if (baud_wrap) begin
            state_q  <= S_STOP;
            serial_q <= 1'b1;
          end
        end
        S_STOP: begin
          baud_q <= baud_d;
          if (baud_wrap) begin
            state_q  <= S_IDLE;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          baud_q   <= '0;
          serial_q <= 1'b1;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready  = ready_q;
  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_parity_frame_serializer.sv
// Bench for parity_frame_serializer: directed frame table, back-to-back,
// ignored mid-frame valid, mid-frame reset, and random words vs a frame model.
`timescale 1ns/1ps
`default_nettype none

module tb_parity_frame_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [8:0] data0, data1;
  logic       valid0, valid1;
  logic       ready0, serial0, busy0, done0;
  logic       ready1, serial1, busy1, done1;

  parity_frame_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .data_in_with_parity(data0), .tx_valid(valid0),
    .tx_ready(ready0), .tx_serial(serial0), .tx_busy(busy0), .tx_done(done0));

  parity_frame_serializer #(.CLKS_PER_BIT(2), .PARITY_EN(1'b0)) u_dut_np (
    .clk(clk), .rst_n(rst_n), .data_in_with_parity(data1), .tx_valid(valid1),
    .tx_ready(ready1), .tx_serial(serial1), .tx_busy(busy1), .tx_done(done1));

  int checks = 0;
  int passes = 0;

  typedef struct {
    int         sel;
    logic [8:0] word;
    logic [10:0] frame;   // transmit order, first bit in [10]
    int         nbits;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // {serial, busy, done, ready}
  function automatic logic [3:0] outs(input int sel);
    return (sel == 0) ? {serial0, busy0, done0, ready0} : {serial1, busy1, done1, ready1};
  endfunction

  task automatic drive(input int sel, input logic v, input logic [8:0] d);
    if (sel == 0) begin valid0 = v; data0 = d; end
    else begin valid1 = v; data1 = d; end
  endtask

  // Reference: frame from the word's fields, independent of any timing.
  function automatic logic [10:0] model_frame(input logic [8:0] word, input bit pen);
    bit q[$];
    logic [10:0] f;
    f = '0;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(word[i+1]);
    if (pen) q.push_back(word[0]);
    q.push_back(1'b1);
    for (int i = 0; i < q.size(); i++) f[10-i] = q[i];
    return f;
  endfunction

  // Entered and left at a negedge with the DUT idle.
  task automatic run_frame(input int sel, input logic [8:0] word, input logic [10:0] frame,
                           input int nbits, input string tag, input bit hold,
                           input logic [8:0] next_word, input int pulse_at);
    int cpb;
    int len;
    logic [3:0] o;
    cpb = (sel == 0) ? 4 : 2;
    len = nbits * cpb;
    o = outs(sel);
    check($sformatf("%s ready_before", tag), o[0], 1);
    drive(sel, 1'b1, word);
    @(posedge clk);
    @(negedge clk);
    if (hold) drive(sel, 1'b1, next_word);
    else drive(sel, 1'b0, ~word);
    for (int k = 1; k <= len; k++) begin
      o = outs(sel);
      check($sformatf("%s line c%0d", tag, k), o[3], frame[10-(k-1)/cpb]);
      check($sformatf("%s busy c%0d", tag, k), o[2], 1);
      check($sformatf("%s done c%0d", tag, k), o[1], (k == len));
      check($sformatf("%s ready c%0d", tag, k), o[0], 0);
      if (pulse_at > 0 && k == pulse_at) drive(sel, 1'b1, 9'h0F0);
      else if (pulse_at > 0 && k == pulse_at + 1) drive(sel, 1'b0, ~word);
      @(negedge clk);
    end
    o = outs(sel);
    check($sformatf("%s idle ready", tag), o[0], 1);
    check($sformatf("%s idle busy", tag), o[2], 0);
    check($sformatf("%s idle done", tag), o[1], 0);
    check($sformatf("%s idle line", tag), o[3], 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] w;
    int sel;

    vecs[0] = '{0, 9'h14A, 11'b01010010101, 11};             // A5, even parity 0
    vecs[1] = '{0, 9'h001, 11'b00000000011, 11};             // 00, odd parity 1
    vecs[2] = '{1, 9'h102, {10'b0100000011, 1'b0}, 10};      // 81, no parity slot
    vecs[3] = '{0, 9'h14B, 11'b01010010111, 11};             // wrong parity sent as-is
    vecs[4] = '{1, 9'h1FF, {10'b0111111111, 1'b0}, 10};

    rst_n = 1'b0;
    drive(0, 1'b0, 9'h000);
    drive(1, 1'b0, 9'h000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst serial0", serial0, 1);
    check("rst ready0", ready0, 1);
    check("rst busy0", busy0, 0);
    check("rst done0", done0, 0);
    check("rst serial1", serial1, 1);
    check("rst ready1", ready1, 1);
    check("rst busy1", busy1, 0);
    check("rst done1", done1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_frame(vecs[i].sel, vecs[i].word, vecs[i].frame, vecs[i].nbits,
                $sformatf("vec%0d", i), 1'b0, 9'h000, 0);

    // Valid held high across two words: second one accepted after one IDLE cycle.
    run_frame(0, 9'h1FF, 11'b01111111111, 11, "b2b_a", 1'b1, 9'h002, 0);
    run_frame(0, 9'h002, 11'b01000000001, 11, "b2b_b", 1'b0, 9'h000, 0);

    // Valid pulsed mid-frame must be dropped, not queued.
    run_frame(0, 9'h0A4, model_frame(9'h0A4, 1'b1), 11, "midvalid", 1'b0, 9'h000, 10);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("no_extra busy c%0d", k), busy0, 0);
      check($sformatf("no_extra line c%0d", k), serial0, 1);
      @(negedge clk);
    end

    for (int n = 0; n < 16; n++) begin
      sel = $urandom_range(0, 1);
      w = 9'($urandom);
      run_frame(sel, w, model_frame(w, sel == 0), (sel == 0) ? 11 : 10,
                $sformatf("rnd%0d_w%03h", n, w), 1'b0, 9'h000, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in DATA bit 3 (cycles 17..20 at 4 clocks per bit): A5 bit 3 is 0.
    drive(0, 1'b1, 9'h14A);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 9'h000);
    repeat (17) @(negedge clk);
    check("pre_rst line", serial0, 0);
    check("pre_rst busy", busy0, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst line", serial0, 1);
    check("mid_rst busy", busy0, 0);
    check("mid_rst ready", ready0, 1);
    check("mid_rst done", done0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check($sformatf("post_rst done c%0d", k), done0, 0);
      check($sformatf("post_rst busy c%0d", k), busy0, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
